// File: rtl/hazard_forward_unit.sv
// Hazard detection and operand forwarding for the pipelined core.
// Produces registered per-source forwarding selects and a load-use stall/bubble.
module hazard_forward_unit #(
    parameter int REG_ADDR_W   = 2,
    parameter int NUM_SRC      = 2,
    parameter int LOAD_USE_LAT = 1,
    parameter int ZERO_REG_EN  = 0,
    parameter int STALL_CNT_W  = 16
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          id_valid,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] id_rs,
    input  logic [NUM_SRC-1:0]            id_rs_used,
    input  logic                          ex_valid,
    input  logic [REG_ADDR_W-1:0]         ex_rd,
    input  logic                          ex_reg_write,
    input  logic                          ex_mem_read,
    input  logic                          mem_valid,
    input  logic [REG_ADDR_W-1:0]         mem_rd,
    input  logic                          mem_reg_write,
    input  logic                          flush,
    input  logic                          cnt_clr,
    output logic [2*NUM_SRC-1:0]          fwd_sel,
    output logic                          stall,
    output logic                          bubble,
    output logic [STALL_CNT_W-1:0]        stall_cycles
);

    typedef enum logic {RUN, BUBBLE} state_t;

    localparam logic [3:0] BUB_INIT = (LOAD_USE_LAT > 1) ? 4'(LOAD_USE_LAT - 2) : 4'd0;

    state_t                 state;
    logic [3:0]             cnt;
    logic [NUM_SRC-1:0]     match_ex;
    logic [NUM_SRC-1:0]     match_mem;
    logic [REG_ADDR_W-1:0]  src;
    logic                   zero_blk;
    logic                   hazard;
    logic [2*NUM_SRC-1:0]   fwd_nxt;

    always_comb begin
        match_ex  = '0;
        match_mem = '0;
        src       = '0;
        zero_blk  = 1'b0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            src          = id_rs[i*REG_ADDR_W +: REG_ADDR_W];
            zero_blk     = (ZERO_REG_EN != 0) && (src == '0);
            match_ex[i]  = id_rs_used[i] & ex_valid & ex_reg_write & (src == ex_rd) & ~zero_blk;
            match_mem[i] = id_rs_used[i] & mem_valid & mem_reg_write & (src == mem_rd) & ~zero_blk;
        end
    end

    assign hazard = id_valid & (|match_ex) & ex_mem_read;
    // Gated with reset_n so the outputs are quiet while reset is held.
    assign stall  = reset_n & ~flush & ((state == BUBBLE) | hazard);
    assign bubble = stall & ~flush;

    always_comb begin
        fwd_nxt = '0;
        if (!flush && !stall && id_valid) begin
            for (int unsigned i = 0; i < NUM_SRC; i++) begin
                if (match_ex[i] && !ex_mem_read)
                    fwd_nxt[2*i +: 2] = 2'd2;
                else if (match_mem[i])
                    fwd_nxt[2*i +: 2] = 2'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= RUN;
            cnt     <= '0;
            fwd_sel <= '0;
        end else begin
            fwd_sel <= fwd_nxt;
            if (flush) begin
                state <= RUN;
                cnt   <= '0;
            end else begin
                case (state)
                    RUN: begin
                        if (stall && LOAD_USE_LAT > 1) begin
                            state <= BUBBLE;
                            cnt   <= BUB_INIT;
                        end
                    end
                    BUBBLE: begin
                        if (cnt == '0)
                            state <= RUN;
                        else
                            cnt <= cnt - 4'd1;
                    end
                    default: begin
                        state <= RUN;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            stall_cycles <= '0;
        else if (cnt_clr)
            stall_cycles <= '0;
        else if (stall && stall_cycles != '1)
            stall_cycles <= stall_cycles + 1'b1;
    end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Self-checking bench: four parameterisations share one stimulus set; table
// vectors with a forwarding scoreboard, then hand-written multi-cycle sequences.
module tb_hazard_forward_unit;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       id_valid;
    logic [3:0] id_rs;
    logic [1:0] id_rs_used;
    logic       ex_valid, ex_reg_write, ex_mem_read;
    logic [1:0] ex_rd;
    logic       mem_valid, mem_reg_write;
    logic [1:0] mem_rd;
    logic       flush, cnt_clr;

    logic [3:0]  fwd_d, fwd_z, fwd_l3, fwd_w2;
    logic        stall_d, stall_z, stall_l3, stall_w2;
    logic        bub_d, bub_z, bub_l3, bub_w2;
    logic [15:0] sc_d, sc_z, sc_l3;
    logic [1:0]  sc_w2;

    int total = 0;
    int passed = 0;

    always #5 clk = ~clk;

    hazard_forward_unit u_def (
        .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .id_rs(id_rs), .id_rs_used(id_rs_used),
        .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
        .flush(flush), .cnt_clr(cnt_clr),
        .fwd_sel(fwd_d), .stall(stall_d), .bubble(bub_d), .stall_cycles(sc_d));

    hazard_forward_unit #(.ZERO_REG_EN(1)) u_zero (
        .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .id_rs(id_rs), .id_rs_used(id_rs_used),
        .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
        .flush(flush), .cnt_clr(cnt_clr),
        .fwd_sel(fwd_z), .stall(stall_z), .bubble(bub_z), .stall_cycles(sc_z));

    hazard_forward_unit #(.LOAD_USE_LAT(3)) u_lat3 (
        .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .id_rs(id_rs), .id_rs_used(id_rs_used),
        .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
        .flush(flush), .cnt_clr(cnt_clr),
        .fwd_sel(fwd_l3), .stall(stall_l3), .bubble(bub_l3), .stall_cycles(sc_l3));

    hazard_forward_unit #(.STALL_CNT_W(2)) u_w2 (
        .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .id_rs(id_rs), .id_rs_used(id_rs_used),
        .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
        .flush(flush), .cnt_clr(cnt_clr),
        .fwd_sel(fwd_w2), .stall(stall_w2), .bubble(bub_w2), .stall_cycles(sc_w2));

    typedef struct {
        string    name;
        bit       idv;
        bit [1:0] rs1, rs0, used;
        bit       exv;
        bit [1:0] exrd;
        bit       exrw, exmr, memv;
        bit [1:0] memrd;
        bit       memrw, fl;
        bit       st;
        bit [3:0] fwd;
        bit       stz;
        bit [3:0] fwdz;
    } vec_t;

    vec_t vecs[15];
    logic [7:0] sb[$];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic idle();
        id_valid = 0; id_rs = '0; id_rs_used = '0;
        ex_valid = 0; ex_rd = '0; ex_reg_write = 0; ex_mem_read = 0;
        mem_valid = 0; mem_rd = '0; mem_reg_write = 0;
        flush = 0; cnt_clr = 0;
    endtask

    task automatic drive(input vec_t v);
        id_valid = v.idv; id_rs = {v.rs1, v.rs0}; id_rs_used = v.used;
        ex_valid = v.exv; ex_rd = v.exrd; ex_reg_write = v.exrw; ex_mem_read = v.exmr;
        mem_valid = v.memv; mem_rd = v.memrd; mem_reg_write = v.memrw;
        flush = v.fl;
    endtask

    // Load in EX writing r3, ID reads r3 on src1
    task automatic load_use();
        idle();
        id_valid = 1; id_rs = {2'd3, 2'd0}; id_rs_used = 2'b11;
        ex_valid = 1; ex_rd = 2'd3; ex_reg_write = 1; ex_mem_read = 1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle();
        reset_n = 0;
        #2;
        @(negedge clk);
        reset_n = 1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0]  = '{"add_fwd",      1, 2, 1, 2'b11, 1, 1, 1, 0, 1, 2, 1, 0, 0, 4'b0110, 0, 4'b0110};
        vecs[1]  = '{"load_use",     1, 3, 0, 2'b11, 1, 3, 1, 1, 0, 0, 0, 0, 1, 4'b0000, 1, 4'b0000};
        vecs[2]  = '{"load_in_mem",  1, 3, 0, 2'b11, 0, 3, 1, 1, 1, 3, 1, 0, 0, 4'b0100, 0, 4'b0100};
        vecs[3]  = '{"ex_beats_mem", 1, 0, 2, 2'b01, 1, 2, 1, 0, 1, 2, 1, 0, 0, 4'b0010, 0, 4'b0010};
        vecs[4]  = '{"unused_src",   1, 0, 1, 2'b00, 1, 1, 1, 1, 1, 1, 1, 0, 0, 4'b0000, 0, 4'b0000};
        vecs[5]  = '{"id_invalid",   0, 1, 1, 2'b11, 1, 1, 1, 0, 1, 1, 1, 0, 0, 4'b0000, 0, 4'b0000};
        vecs[6]  = '{"id_inv_load",  0, 1, 1, 2'b11, 1, 1, 1, 1, 0, 0, 0, 0, 0, 4'b0000, 0, 4'b0000};
        vecs[7]  = '{"flush_hazard", 1, 0, 1, 2'b01, 1, 1, 1, 1, 0, 0, 0, 1, 0, 4'b0000, 0, 4'b0000};
        vecs[8]  = '{"flush_fwd",    1, 0, 1, 2'b01, 1, 1, 1, 0, 1, 1, 1, 1, 0, 4'b0000, 0, 4'b0000};
        vecs[9]  = '{"ex_invalid",   1, 0, 1, 2'b01, 0, 1, 1, 0, 1, 1, 1, 0, 0, 4'b0001, 0, 4'b0001};
        vecs[10] = '{"r0_fwd",       1, 0, 0, 2'b01, 1, 0, 1, 0, 0, 0, 0, 0, 0, 4'b0010, 0, 4'b0000};
        vecs[11] = '{"r0_load",      1, 0, 0, 2'b01, 1, 0, 1, 1, 0, 0, 0, 0, 1, 4'b0000, 0, 4'b0000};
        vecs[12] = '{"no_wr_load",   1, 0, 1, 2'b01, 1, 1, 0, 1, 1, 1, 0, 0, 0, 4'b0000, 0, 4'b0000};
        vecs[13] = '{"split_src",    1, 1, 2, 2'b11, 1, 1, 1, 0, 1, 2, 1, 0, 0, 4'b1001, 0, 4'b1001};
        vecs[14] = '{"mem_nowr",     1, 0, 2, 2'b01, 0, 0, 0, 0, 1, 2, 0, 0, 0, 4'b0000, 0, 4'b0000};

        // Reset state, with a hazard present while reset is held
        idle();
        reset_n = 0;
        load_use();
        #3;
        chk("rst_stall", stall_d, 0);
        chk("rst_bubble", bub_d, 0);
        chk("rst_fwd", fwd_d, 0);
        chk("rst_cnt", sc_d, 0);
        chk("rst_stall_l3", stall_l3, 0);
        do_reset();

        // Table vectors through the default and zero-register instances
        foreach (vecs[k]) begin
            @(negedge clk);
            drive(vecs[k]);
            sb.push_back({vecs[k].fwdz, vecs[k].fwd});
            #1;
            chk({vecs[k].name, "_stall"}, stall_d, vecs[k].st);
            chk({vecs[k].name, "_bubble"}, bub_d, vecs[k].st);
            chk({vecs[k].name, "_stall_z"}, stall_z, vecs[k].stz);
            @(posedge clk);
            #1;
            if (sb.size() == 0) begin
                chk({vecs[k].name, "_sb_empty"}, 1, 0);
            end else begin
                logic [7:0] e;
                e = sb.pop_front();
                chk({vecs[k].name, "_fwd"}, fwd_d, e[3:0]);
                chk({vecs[k].name, "_fwd_z"}, fwd_z, e[7:4]);
            end
        end
        chk("table_cnt_def", sc_d, 2);
        chk("table_cnt_zero", sc_z, 1);

        // Load-use with default latency, then the load reaches MEM
        do_reset();
        load_use();
        #1;
        chk("lu_stall", stall_d, 1);
        chk("lu_bubble", bub_d, 1);
        @(negedge clk);
        ex_valid = 0; mem_valid = 1; mem_rd = 2'd3; mem_reg_write = 1;
        #1;
        chk("lu_stall_gone", stall_d, 0);
        chk("lu_fwd_after_stall", fwd_d, 0);
        @(posedge clk);
        #1;
        chk("lu_fwd_mem", fwd_d, 4'b0100);
        chk("lu_cnt", sc_d, 1);

        // Three-cycle load-use bubble
        do_reset();
        load_use();
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("lat3_stall_%0d", c), stall_l3, 1);
            @(negedge clk);
        end
        ex_valid = 0; mem_valid = 1; mem_rd = 2'd3; mem_reg_write = 1;
        #1;
        chk("lat3_run", stall_l3, 0);
        @(posedge clk);
        #1;
        chk("lat3_cnt", sc_l3, 3);

        // Flush in the second stall cycle returns to RUN
        do_reset();
        load_use();
        #1;
        chk("fl_stall1", stall_l3, 1);
        @(negedge clk);
        flush = 1;
        #1;
        chk("fl_stall2", stall_l3, 0);
        chk("fl_bubble2", bub_l3, 0);
        @(posedge clk);
        #1;
        chk("fl_fwd", fwd_l3, 0);
        @(negedge clk);
        idle();
        id_valid = 1; id_rs = {2'd0, 2'd2}; id_rs_used = 2'b01;
        mem_valid = 1; mem_rd = 2'd2; mem_reg_write = 1;
        #1;
        chk("fl_no_residual", stall_l3, 0);
        @(posedge clk);
        #1;
        chk("fl_fwd_resume", fwd_l3, 4'b0001);
        chk("fl_cnt", sc_l3, 1);

        // Narrow counter saturates, clear wins over increment
        do_reset();
        load_use();
        repeat (5) @(posedge clk);
        #1;
        chk("w2_sat", sc_w2, 3);
        @(negedge clk);
        cnt_clr = 1;
        #1;
        chk("w2_stall_clr", stall_w2, 1);
        @(posedge clk);
        #1;
        chk("w2_clr", sc_w2, 0);

        // Reset mid-bubble aborts it asynchronously
        do_reset();
        load_use();
        @(negedge clk);
        #1;
        chk("mid_in_bubble", stall_l3, 1);
        chk("mid_cnt_pre", sc_l3, 1);
        #1;
        reset_n = 0;
        #1;
        chk("mid_stall", stall_l3, 0);
        chk("mid_bubble", bub_l3, 0);
        chk("mid_fwd", fwd_l3, 0);
        chk("mid_cnt", sc_l3, 0);
        @(negedge clk);
        idle();
        reset_n = 1;
        #1;
        chk("mid_release", stall_l3, 0);
        @(negedge clk);
        #1;
        chk("mid_release2", stall_l3, 0);
        chk("mid_cnt_post", sc_l3, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
